// File: rtl/fir_out_buffer.sv
// FIR output buffer: DEPTH-entry FIFO with a registered AXIS head, regenerated tlast and
// frame-length checking. Define FIR_OUT_SAT_EN to saturate samples to SAT_BITS on push.
module fir_out_buffer #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 8,
  parameter int SAT_BITS    = 16
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst_n,
  input  logic                     cfg_start,
  input  logic [31:0]              cfg_length,
  input  logic                     s_tvalid,
  input  logic [pDATA_WIDTH-1:0]   s_tdata,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     m_tvalid,
  output logic [pDATA_WIDTH-1:0]   m_tdata,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_tlast,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);

  // Handshake: a beat transfers on a rising edge where valid && ready; a source never
  // withdraws valid or changes payload while waiting for ready.
  logic [pDATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr, rd_nxt;
  logic [31:0]            len, in_cnt;
  logic                   zero_done;
  logic                   full, push, pop, last_in;
  logic [pDATA_WIDTH-1:0] push_data;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [pDATA_WIDTH-1:0] SAT_MAX =
    pDATA_WIDTH'((64'sd1 <<< (SAT_BITS-1)) - 64'sd1);
  localparam logic signed [pDATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    push_data = s_tdata;
    if ($signed(s_tdata) > SAT_MAX)      push_data = SAT_MAX;
    else if ($signed(s_tdata) < SAT_MIN) push_data = SAT_MIN;
  end
`else
  assign push_data = s_tdata;
`endif

  assign full       = (level == LEVEL_FULL);
  assign s_tready   = (state == S_RUN) && !full;
  assign push       = s_tvalid && s_tready;
  assign m_tvalid   = (level != '0);
  assign pop        = m_tvalid && m_tready;
  assign last_in    = (in_cnt == len - 32'd1);
  assign rd_nxt     = rd_ptr + AW'(1);
  assign busy       = (state != S_IDLE);
  assign frame_done = zero_done || ((state == S_DRAIN) && pop && m_tlast);

  always_ff @(posedge axis_clk) begin
    if (push) mem[wr_ptr] <= {last_in, push_data};
  end

  // The head register always mirrors the oldest entry, which still counts in level.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      m_tdata <= '0;
      m_tlast <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        if (level > LEVEL_ONE) {m_tlast, m_tdata} <= mem[rd_nxt];
        else if (push)         {m_tlast, m_tdata} <= {last_in, push_data};
      end else if ((level == '0) && push) begin
        {m_tlast, m_tdata} <= {last_in, push_data};
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      in_cnt    <= '0;
      err_tlast <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_length != 32'd0) begin
              len       <= cfg_length;
              in_cnt    <= '0;
              err_tlast <= 1'b0;
              state     <= S_RUN;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (push) begin
            in_cnt <= in_cnt + 32'd1;
            if (s_tlast != last_in) err_tlast <= 1'b1;
            if (last_in) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && m_tlast) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_buffer.sv
// Bench for fir_out_buffer: directed and random frames checked against an expected-beat queue.
module tb_fir_out_buffer;

  localparam int W = 32;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [31:0]   cfg_length = '0;
  logic          s_tvalid = 1'b0;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic [W-1:0]  m_tdata;
  logic          m_tlast;
  logic          m_tready;
  logic          busy, frame_done, err_tlast;
  logic [3:0]    level;
  logic [1:0]    state;

  logic          fix_ready = 1'b0;
  logic          rnd_ready = 1'b0;
  logic          rnd_on = 1'b0;
  assign m_tready = rnd_on ? rnd_ready : fix_ready;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  fir_out_buffer #(.pDATA_WIDTH(W), .DEPTH(8), .SAT_BITS(16)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .cfg_start(cfg_start), .cfg_length(cfg_length),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .frame_done(frame_done), .err_tlast(err_tlast),
    .level(level), .state(state)
  );

  // clock / reset
  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    #1 rnd_ready = ($urandom_range(0, 2) != 0);
  end

  // scoreboard monitor, sampled on the falling edge
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  always @(negedge axis_clk) begin
    logic [W:0] exp;
    if (!axis_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b, need v=1 d=%0d l=%0b",
                   m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_beat: got d=%0d l=%0b, need no beat", m_tdata, m_tlast);
        end else begin
          exp = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== exp) begin
            errors++;
            $display("FAIL beat: got d=%0d l=%0b, need d=%0d l=%0b",
                     m_tdata, m_tlast, exp[W-1:0], exp[W]);
          end
        end
      end
      if (frame_done) done_cnt++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] d);
`ifdef FIR_OUT_SAT_EN
    if ($signed(d) > 32'sd32767)  return 32'd32767;
    if ($signed(d) < -32'sd32768) return 32'hFFFF_8000;
`endif
    return d;
  endfunction

  // driver tasks: all start and end at posedge + 1
  task automatic start_frame(input logic [31:0] n);
    cfg_start = 1'b1;
    cfg_length = n;
    @(posedge axis_clk); #1;
    cfg_start = 1'b0;
    cfg_length = $urandom;
  endtask

  task automatic push_sample(input logic [W-1:0] d, input logic l, input logic exp_last);
    logic acc = 1'b0;
    int t = 0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tlast = l;
    while (!acc && t < 300) begin
      @(negedge axis_clk);
      acc = s_tready;
      @(posedge axis_clk); #1;
      t++;
    end
    if (acc) exp_q.push_back({exp_last, model(d)});
    else begin
      checks++; errors++;
      $display("FAIL push_timeout: got s_tready=0 for %0d cycles, need accept", t);
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(posedge axis_clk); #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending busy=%0b, need 0 pending busy=0",
               exp_q.size(), busy);
    end
    repeat (2) @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge axis_clk);
    #1;
    checks++;
    if ({s_tready, m_tvalid, m_tlast, busy, frame_done, err_tlast} !== 6'b0 ||
        m_tdata !== '0 || level !== '0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_in: got rdy=%0b v=%0b d=%0d l=%0b busy=%0b fd=%0b err=%0b lvl=%0d st=%0d, need all 0",
               s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done, err_tlast, level, state);
    end
    axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%0b busy=%0b rdy=%0b, need 0 0 0", m_tvalid, busy, s_tready);
    end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    fix_ready = 1'b1;
    start_frame(11);
    checks++;
    if (busy !== 1'b1 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL basic_arm: got busy=%0b rdy=%0b, need 1 1", busy, s_tready);
    end
    for (int i = 1; i <= 11; i++) begin
      push_sample(W'(i), (i == 11), (i == 11));
      if (i == 1) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'd1) begin
          errors++;
          $display("FAIL basic_latency: got v=%0b d=%0d, need v=1 d=1", m_tvalid, m_tdata);
        end
      end
    end
    wait_drain();
    checks++;
    if (done_cnt !== d0 + 1 || err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got pulses=%0d err=%0b, need 1 0", done_cnt - d0, err_tlast);
    end
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    fix_ready = 1'b0;
    start_frame(20);
    for (int i = 0; i < 8; i++) push_sample(W'(100 + i), 1'b0, 1'b0);
    s_tvalid = 1'b1;
    s_tdata = 32'd108;
    @(negedge axis_clk);
    checks++;
    if (s_tready !== 1'b0 || level !== 4'd8) begin
      errors++;
      $display("FAIL bp_full: got rdy=%0b lvl=%0d, need rdy=0 lvl=8", s_tready, level);
    end
    @(posedge axis_clk); #1;
    fix_ready = 1'b1;
    for (int i = 8; i < 20; i++) push_sample(W'(100 + i), (i == 19), (i == 19));
    wait_drain();
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL bp_done: got pulses=%0d, need 1", done_cnt - d0);
    end
  endtask

  task automatic test_random();
    int d0 = done_cnt;
    rnd_on = 1'b1;
    start_frame(600);
    for (int i = 0; i < 600; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge axis_clk); #1;
      end
      push_sample($urandom, (i == 599), (i == 599));
    end
    wait_drain();
    rnd_on = 1'b0;
    fix_ready = 1'b1;
    checks++;
    if (done_cnt !== d0 + 1 || err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL rand_done: got pulses=%0d err=%0b, need 1 0", done_cnt - d0, err_tlast);
    end
  endtask

  task automatic test_tlast_err();
    fix_ready = 1'b1;
    start_frame(5);
    for (int i = 1; i <= 5; i++) push_sample(W'(i * 7), (i == 3), (i == 5));
    wait_drain();
    checks++;
    if (err_tlast !== 1'b1) begin
      errors++;
      $display("FAIL tlast_err_set: got err=%0b, need 1", err_tlast);
    end
    start_frame(1);
    checks++;
    if (err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL tlast_err_clear: got err=%0b, need 0", err_tlast);
    end
    push_sample(32'd55, 1'b1, 1'b1);
    wait_drain();
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt;
    start_frame(0);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: got fd=%0b busy=%0b, need 1 0", frame_done, busy);
    end
    repeat (3) @(posedge axis_clk);
    #1;
    checks++;
    if (done_cnt !== d0 + 1 || m_tvalid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL zero_len: got pulses=%0d v=%0b lvl=%0d, need 1 0 0", done_cnt - d0, m_tvalid, level);
    end
  endtask

  task automatic test_sat();
    logic [W-1:0] ins [3];
    logic [W-1:0] outs [3];
    ins[0] = 32'd40000; ins[1] = -32'sd40000; ins[2] = 32'd1234;
`ifdef FIR_OUT_SAT_EN
    outs[0] = 32'd32767; outs[1] = 32'hFFFF_8000; outs[2] = 32'd1234;
`else
    outs[0] = ins[0]; outs[1] = ins[1]; outs[2] = ins[2];
`endif
    fix_ready = 1'b0;
    start_frame(3);
    for (int i = 0; i < 3; i++) push_sample(ins[i], (i == 2), (i == 2));
    checks++;
    if (m_tdata !== outs[0] || level !== 4'd3) begin
      errors++;
      $display("FAIL sat_head: got d=%0d lvl=%0d, need d=%0d lvl=3", $signed(m_tdata), level, $signed(outs[0]));
    end
    fix_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    fix_ready = 1'b0;
    start_frame(10);
    for (int i = 0; i < 4; i++) push_sample(W'(200 + i), 1'b0, 1'b0);
    checks++;
    if (level !== 4'd4 || m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill: got lvl=%0d v=%0b, need 4 1", level, m_tvalid);
    end
    axis_rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (level !== '0 || m_tvalid !== 1'b0 || state !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got lvl=%0d v=%0b st=%0d busy=%0b, need 0 0 0 0", level, m_tvalid, state, busy);
    end
    fix_ready = 1'b1;
    repeat (2) @(posedge axis_clk);
    #1 axis_rst_n = 1'b1;
    repeat (4) @(posedge axis_clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL mid_after: got v=%0b lvl=%0d, need 0 0", m_tvalid, level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_tlast_err();
    test_zero_len();
    test_sat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
